melody_sequencer: RTL and testbench
===================================

MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 500000, SHALL set clk cycles per duration tick (10 ms at 50 MHz).
REQ-002 Parameter GAP_TICKS, default 2, SHALL set the silent ticks inserted after every note; 0 means no gap.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 start  in  1  level sampled each cycle; SHALL begin playback from entry 0 when seen in IDLE.
REQ-006 stop  in  1  SHALL abort playback.
REQ-007 loop_en  in  1  SHALL select restart at entry 0 after the last entry.
REQ-008 wr_en  in  1  SHALL write wr_data into the note memory at wr_addr.
REQ-009 wr_addr  in  4  SHALL give the note memory index (16 entries).
REQ-010 wr_data  in  12  SHALL give the entry: [11] end flag; [10] octave; [9:7] note code (0 = rest, 1..7 = key); [6:0] duration in ticks.
REQ-011 key_out  out  7  SHALL drive the one-hot key bus of the tone generator; code n sets bit n-1; all zeros = silence.
REQ-012 octave_out  out  1  SHALL drive the tone generator octave select.
REQ-013 busy  out  1  SHALL be high in every state except IDLE.
REQ-014 done  out  1  SHALL be a one-cycle pulse at normal end of a non-looping playback.
REQ-015 cur_addr  out  4  SHALL show the entry being played; 0 in IDLE.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, NOTE and GAP.
REQ-017 Writes SHALL take effect only in IDLE; wr_en in any other state SHALL be ignored.
REQ-018 IDLE: start=1 and stop=0 SHALL set cur_addr=0 and enter LOAD.
REQ-019 LOAD SHALL last exactly 1 cycle, register entry[cur_addr] and enter NOTE.
REQ-020 NOTE: key_out and octave_out SHALL come from the registered entry; the key SHALL appear on the first NOTE cycle, 2 cycles after start is sampled.
REQ-021 NOTE SHALL last exactly max(dur,1)*TICK_DIV cycles; the tick prescaler SHALL clear on entry to NOTE and on entry to GAP.
REQ-022 GAP: key_out SHALL be 0 and octave_out SHALL hold; GAP SHALL last GAP_TICKS*TICK_DIV cycles; with GAP_TICKS=0 the FSM SHALL go from NOTE directly to the next-entry decision.
REQ-023 Next-entry decision: if the entry is not last, cur_addr SHALL increment and the FSM SHALL enter LOAD.
REQ-024 An entry is last if its end flag is set; entry 15 SHALL always count as last, so cur_addr never wraps 15->0 except by looping.
REQ-025 Last entry with loop_en=1 (sampled at the decision cycle): cur_addr SHALL become 0 and the FSM SHALL enter LOAD; done SHALL NOT pulse.
REQ-026 Last entry with loop_en=0: the FSM SHALL enter IDLE, pulse done for 1 cycle, and set key_out=0 and cur_addr=0.
REQ-027 stop=1 in any non-IDLE state SHALL force IDLE on the next edge, with key_out=0, cur_addr=0 and no done pulse.
REQ-028 stop and start high in the same cycle SHALL leave the block in IDLE (stop wins).
REQ-029 start while busy SHALL be ignored; start held high continuously SHALL retrigger only from IDLE.
REQ-030 Note code 0 SHALL play as silence of the given duration; this is still counted as a note and is followed by a gap.
REQ-031 Duration and prescaler counters SHALL be wide enough for 127*TICK_DIV without overflow.

Reset
REQ-032 While rst_n=0: state=IDLE, key_out=0, octave_out=0, busy=0, done=0, cur_addr=0, counters=0; note memory contents are undefined and not reset.
REQ-033 rst_n asserting mid-playback SHALL silence key_out immediately (asynchronously).

Verification (TICK_DIV=4, GAP_TICKS=1)
REQ-034 Write entry0=note1 dur2, entry1=note3 octave1 dur1 end; pulse start -> key_out=0000001 for 8 cycles, 0 for 4, then 0000100 with octave_out=1 for 4, 0 for 4, then a 1-cycle done pulse and busy=0.
REQ-035 Same program with loop_en=1 -> after entry1's gap, LOAD then key_out=0000001 again; no done pulse; cur_addr goes 1->0.
REQ-036 Assert stop on the 3rd NOTE cycle -> next cycle: busy=0, key_out=0, no done; a later start replays from entry 0.
REQ-037 Fill 16 entries with no end flag, dur0 -> each note lasts 4 cycles; playback ends after entry 15 with done.
REQ-038 wr_en to entry0 while busy -> memory unchanged, so the next playback uses the original entry0; start and stop in the same IDLE cycle -> busy stays 0.
REQ-039 Drop rst_n mid-NOTE -> key_out=0 before the next clk edge; after release, state is IDLE.

Source files
------------

// File: rtl/melody_sequencer.sv
// Plays a 16-entry note program as one-hot keys for a tone generator, with a silent gap after each note.
// Latency: the first key appears 2 cycles after start is sampled; each note lasts max(dur,1)*TICK_DIV cycles.
// Backpressure: none. stop aborts playback, and start or writes are ignored while busy.
module melody_sequencer #(
    parameter int TICK_DIV  = 500000,
    parameter int GAP_TICKS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        loop_en,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [11:0] wr_data,
    output logic [6:0]  key_out,
    output logic        octave_out,
    output logic        busy,
    output logic        done,
    output logic [3:0]  cur_addr
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW = ($clog2(GAP_TICKS + 1) > 7) ? $clog2(GAP_TICKS + 1) : 7;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_NOTE,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [11:0]     entry_q, entry_d;
    logic [3:0]      addr_q,  addr_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [TW-1:0]   tick_q,  tick_d;
    logic            done_q,  done_d;
    logic [11:0]     mem_q [16];

    logic            presc_wrap;
    logic            note_last;
    logic            gap_last;
    logic            is_last;
    logic            seg_end;
    logic [6:0]      dur_eff;
    logic [6:0]      key_dec;

    // Note memory holds no reset; the program is only writable while idle.
    always_ff @(posedge clk) begin
        if (wr_en && (state_q == S_IDLE)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        dur_eff    = (entry_q[6:0] == 7'd0) ? 7'd1 : entry_q[6:0];
        presc_wrap = (presc_q == PRESC_LAST);
        note_last  = (tick_q == TW'(dur_eff - 7'd1));
        gap_last   = (tick_q == GAP_LAST);
        is_last    = entry_q[11] || (addr_q == 4'd15);
    end

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        addr_d  = addr_q;
        presc_d = presc_q;
        tick_d  = tick_q;
        done_d  = 1'b0;
        seg_end = 1'b0;

        if (presc_wrap) begin
            presc_d = '0;
            tick_d  = tick_q + TW'(1);
        end else begin
            presc_d = presc_q + PW'(1);
        end

        case (state_q)
            S_IDLE: begin
                addr_d  = 4'd0;
                presc_d = '0;
                tick_d  = '0;
                if (start && !stop) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                entry_d = mem_q[addr_q];
                presc_d = '0;
                tick_d  = '0;
                state_d = S_NOTE;
            end
            S_NOTE: begin
                if (presc_wrap && note_last) begin
                    presc_d = '0;
                    tick_d  = '0;
                    if (GAP_TICKS > 0) begin
                        state_d = S_GAP;
                    end else begin
                        seg_end = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (presc_wrap && gap_last) begin
                    presc_d = '0;
                    tick_d  = '0;
                    seg_end = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // End of a note (and its gap): advance, loop back, or finish.
        if (seg_end) begin
            if (!is_last) begin
                addr_d  = addr_q + 4'd1;
                state_d = S_LOAD;
            end else if (loop_en) begin
                addr_d  = 4'd0;
                state_d = S_LOAD;
            end else begin
                addr_d  = 4'd0;
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        end

        if (stop && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            addr_d  = 4'd0;
            presc_d = '0;
            tick_d  = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            entry_q <= '0;
            addr_q  <= '0;
            presc_q <= '0;
            tick_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            addr_q  <= addr_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    // Keys decode from registered state, so an async reset silences them at once.
    always_comb begin
        key_dec = '0;
        if ((state_q == S_NOTE) && (entry_q[9:7] != 3'd0)) begin
            key_dec[entry_q[9:7] - 3'd1] = 1'b1;
        end
    end

    assign key_out    = key_dec;
    assign octave_out = entry_q[10];
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign cur_addr   = addr_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with TICK_DIV=4, GAP_TICKS=1.
module tb_melody_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        loop_en;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [11:0] wr_data;
    logic [6:0]  key_out;
    logic        octave_out;
    logic        busy;
    logic        done;
    logic [3:0]  cur_addr;

    logic [13:0] obs;
    int          n_checks;
    int          n_errors;

    localparam logic [11:0] ENTRY0 = 12'h082; // note1, dur2
    localparam logic [11:0] ENTRY1 = 12'hD81; // end, octave1, note3, dur1
    localparam logic [11:0] BADENT = 12'h281; // note5, dur1

    melody_sequencer #(
        .TICK_DIV  (4),
        .GAP_TICKS (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .key_out    (key_out),
        .octave_out (octave_out),
        .busy       (busy),
        .done       (done),
        .cur_addr   (cur_addr)
    );

    assign obs = {busy, done, octave_out, cur_addr, key_out};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Checks n consecutive cycles of {busy,done,oct,addr,key}, sampled at negedge.
    task automatic expect_seg(input string tag, input int n, input logic [6:0] key,
                              input logic oct, input logic [3:0] addr,
                              input logic bsy, input logic dn);
        for (int i = 0; i < n; i++) begin
            check(tag, {18'd0, obs}, {18'd0, bsy, dn, oct, addr, key});
            @(negedge clk);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [11:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Full two-entry program; start must be set by the caller at this negedge.
    task automatic play_full(input logic oct0, input logic wr_busy);
        @(negedge clk);
        start = 1'b0;
        if (wr_busy) begin
            wr_en   = 1'b1;
            wr_addr = 4'd0;
            wr_data = BADENT;
        end
        expect_seg("load0", 1, 7'd0,       oct0, 4'd0, 1'b1, 1'b0);
        wr_en = 1'b0;
        expect_seg("note0", 8, 7'b0000001, 1'b0, 4'd0, 1'b1, 1'b0);
        expect_seg("gap0",  4, 7'd0,       1'b0, 4'd0, 1'b1, 1'b0);
        expect_seg("load1", 1, 7'd0,       1'b0, 4'd1, 1'b1, 1'b0);
        expect_seg("note1", 4, 7'b0000100, 1'b1, 4'd1, 1'b1, 1'b0);
        expect_seg("gap1",  4, 7'd0,       1'b1, 4'd1, 1'b1, 1'b0);
        expect_seg("done",  1, 7'd0,       1'b1, 4'd0, 1'b0, 1'b1);
        expect_seg("idle",  2, 7'd0,       1'b1, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [2:0]  code;
        logic [6:0]  k;
        logic        prev_oct;
        logic [3:0]  ia;

        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        loop_en  = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;

        repeat (2) @(negedge clk);
        check("reset", {18'd0, obs}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic two-note program, no loop.
        wr(4'd0, ENTRY0);
        wr(4'd1, ENTRY1);
        start = 1'b1;
        play_full(1'b0, 1'b0);

        // Loop back to entry 0, then stop on the 3rd NOTE cycle.
        loop_en = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        expect_seg("lp_load0", 1, 7'd0,       1'b1, 4'd0, 1'b1, 1'b0);
        expect_seg("lp_note0", 8, 7'b0000001, 1'b0, 4'd0, 1'b1, 1'b0);
        expect_seg("lp_gap0",  4, 7'd0,       1'b0, 4'd0, 1'b1, 1'b0);
        expect_seg("lp_load1", 1, 7'd0,       1'b0, 4'd1, 1'b1, 1'b0);
        expect_seg("lp_note1", 4, 7'b0000100, 1'b1, 4'd1, 1'b1, 1'b0);
        expect_seg("lp_gap1",  4, 7'd0,       1'b1, 4'd1, 1'b1, 1'b0);
        expect_seg("lp_wrap",  1, 7'd0,       1'b1, 4'd0, 1'b1, 1'b0);
        expect_seg("lp_again", 2, 7'b0000001, 1'b0, 4'd0, 1'b1, 1'b0);
        stop = 1'b1;
        @(negedge clk);
        stop    = 1'b0;
        loop_en = 1'b0;
        expect_seg("stopped",  3, 7'd0,       1'b0, 4'd0, 1'b0, 1'b0);

        // Replay from entry 0 with a write attempted while busy.
        start = 1'b1;
        play_full(1'b0, 1'b1);
        start = 1'b1;
        play_full(1'b1, 1'b0);

        // start and stop together in IDLE: stay idle.
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        expect_seg("start_stop", 3, 7'd0, 1'b1, 4'd0, 1'b0, 1'b0);

        // 16 entries, dur 0, no end flag: entry 15 terminates. Code 0 is a rest.
        for (int i = 0; i < 16; i++) begin
            ia = 4'(i);
            wr(ia, {1'b0, ia[0], ia[2:0], 7'd0});
        end
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        prev_oct = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ia   = 4'(i);
            code = ia[2:0];
            k    = (code == 3'd0) ? 7'd0 : (7'd1 << (code - 3'd1));
            expect_seg("f_load", 1, 7'd0, prev_oct, ia, 1'b1, 1'b0);
            expect_seg("f_note", 4, k,    ia[0],    ia, 1'b1, 1'b0);
            expect_seg("f_gap",  4, 7'd0, ia[0],    ia, 1'b1, 1'b0);
            prev_oct = ia[0];
        end
        expect_seg("f_done", 1, 7'd0, 1'b1, 4'd0, 1'b0, 1'b1);
        expect_seg("f_idle", 2, 7'd0, 1'b1, 4'd0, 1'b0, 1'b0);

        // Asynchronous reset mid-NOTE.
        wr(4'd0, ENTRY0);
        wr(4'd1, ENTRY1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_key", {25'd0, key_out}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async", {18'd0, obs}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_seg("post_rst", 2, 7'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        start = 1'b1;
        play_full(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
